// File: rtl/knn_pkg.sv
// Shared definitions for the K-nearest sort sequencer: FSM encoding, sorter sentinel, defaults.
package knn_pkg;

  localparam int unsigned DEFAULT_K         = 1;
  localparam int unsigned DEFAULT_VAL_WIDTH = 32;
  localparam int unsigned DEFAULT_CNT_WIDTH = 32;
  localparam int unsigned NAME_WIDTH        = 32;

  // Name reported by the sorter for slots that never received a candidate
  localparam logic [NAME_WIDTH-1:0] SENTINEL_NAME = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_FLUSH,
    ST_ARM,
    ST_CAPT,
    ST_PRESENT,
    ST_STEP1,
    ST_STEP2,
    ST_SETTLE,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/knn_sort_sequencer.sv
// Per-query controller for the K-nearest sorter: clears it, feeds N indexed distances,
// then drains the K best (name, value) pairs nearest-first onto a valid/ready stream.
module knn_sort_sequencer
  import knn_pkg::*;
#(
  parameter int unsigned K         = DEFAULT_K,
  parameter int unsigned VAL_WIDTH = DEFAULT_VAL_WIDTH,
  parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  cfg_count_i,
  input  logic                  s_valid_i,
  input  logic [VAL_WIDTH-1:0]  s_value_i,
  output logic                  s_ready_o,
  output logic                  sort_clear_o,
  output logic                  sort_valid_o,
  output logic [NAME_WIDTH-1:0] sort_name_o,
  output logic [VAL_WIDTH-1:0]  sort_value_o,
  output logic                  sort_done_o,
  output logic                  sort_out_en_o,
  output logic                  sort_rd_en_o,
  input  logic [NAME_WIDTH-1:0] sort_name_q_i,
  input  logic [VAL_WIDTH-1:0]  sort_value_q_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [NAME_WIDTH-1:0] m_name_o,
  output logic [VAL_WIDTH-1:0]  m_value_o,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  query_done_o
);

  localparam int unsigned PAIR_WIDTH = 32;

  state_e                  state_q;
  logic [CNT_WIDTH-1:0]    n_q;
  logic [CNT_WIDTH-1:0]    idx_q;
  logic [PAIR_WIDTH-1:0]   pairs_q;
  logic                    s_ready_q;
  logic                    sort_clear_q;
  logic                    sort_done_q;
  logic                    sort_rd_en_q;
  logic                    m_valid_q;
  logic [NAME_WIDTH-1:0]   m_name_q;
  logic [VAL_WIDTH-1:0]    m_value_q;
  logic                    m_last_q;
  logic                    busy_q;
  logic                    query_done_q;

  // Sequencer FSM with registered outputs; reset holds the sorter cleared
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      idx_q        <= '0;
      pairs_q      <= '0;
      s_ready_q    <= 1'b0;
      sort_clear_q <= 1'b1;
      sort_done_q  <= 1'b0;
      sort_rd_en_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_name_q     <= '0;
      m_value_q    <= '0;
      m_last_q     <= 1'b0;
      busy_q       <= 1'b0;
      query_done_q <= 1'b0;
    end else begin
      query_done_q <= 1'b0;
      sort_rd_en_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_CLEAR;
            n_q     <= cfg_count_i;
            idx_q   <= '0;
            pairs_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          sort_clear_q <= 1'b0;
          if (n_q != '0) begin
            state_q   <= ST_STREAM;
            s_ready_q <= 1'b1;
          end else begin
            state_q <= ST_FLUSH;
          end
        end
        ST_STREAM: begin
          if (s_valid_i) begin
            idx_q <= idx_q + CNT_WIDTH'(1);
            if (idx_q == n_q - CNT_WIDTH'(1)) begin
              state_q   <= ST_FLUSH;
              s_ready_q <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          state_q     <= ST_ARM;
          sort_done_q <= 1'b1;
        end
        ST_ARM: state_q <= ST_CAPT;
        ST_CAPT: begin
          state_q   <= ST_PRESENT;
          m_valid_q <= 1'b1;
          m_name_q  <= sort_name_q_i;
          m_value_q <= sort_value_q_i;
          m_last_q  <= (pairs_q == PAIR_WIDTH'(K - 1));
        end
        ST_PRESENT: begin
          if (m_ready_i) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            pairs_q   <= pairs_q + PAIR_WIDTH'(1);
            if (m_last_q) begin
              state_q      <= ST_FINISH;
              query_done_q <= 1'b1;
              busy_q       <= 1'b0;
              sort_done_q  <= 1'b0;
            end else begin
              state_q      <= ST_STEP1;
              sort_rd_en_q <= 1'b1;
            end
          end
        end
        // Two rd_en cycles: the first arms the sorter pointer, the second steps it
        ST_STEP1: begin
          state_q      <= ST_STEP2;
          sort_rd_en_q <= 1'b1;
        end
        ST_STEP2:  state_q <= ST_SETTLE;
        ST_SETTLE: state_q <= ST_CAPT;
        ST_FINISH: begin
          state_q      <= ST_IDLE;
          sort_clear_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Distances pass straight through to the sorter only while streaming
  assign sort_valid_o  = s_ready_q & s_valid_i;
  assign sort_value_o  = s_ready_q ? s_value_i : '0;
  assign sort_name_o   = s_ready_q ? NAME_WIDTH'(idx_q) : '0;

  assign s_ready_o     = s_ready_q;
  assign sort_clear_o  = sort_clear_q;
  assign sort_done_o   = sort_done_q;
  assign sort_out_en_o = sort_done_q;
  assign sort_rd_en_o  = sort_rd_en_q;
  assign m_valid_o     = m_valid_q;
  assign m_name_o      = m_name_q;
  assign m_value_o     = m_value_q;
  assign m_last_o      = m_last_q;
  assign busy_o        = busy_q;
  assign query_done_o  = query_done_q;

endmodule

// File: tb/tb_knn_sort_sequencer.sv
// Scoreboard bench: three sequencers (K=4,1,2) each paired with a behavioural sorter,
// results checked against a sort-and-pad reference model.
module tb_knn_sort_sequencer;
  import knn_pkg::*;

  localparam int unsigned VW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned NI = 3;

  typedef struct {
    logic [31:0]   name;
    logic [VW-1:0] value;
    logic          last;
  } pair_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b1;
  logic [CW-1:0] cfg_count = '0;
  logic [VW-1:0] s_value = '0;
  int            sel = 0;
  int            rmode = 0;

  logic          s_ready_a [NI];
  logic          sclr_a    [NI];
  logic          svld_a    [NI];
  logic [31:0]   sname_a   [NI];
  logic [VW-1:0] svalue_a  [NI];
  logic          sdone_a   [NI];
  logic          soe_a     [NI];
  logic          srd_a     [NI];
  logic          m_valid_a [NI];
  logic [31:0]   m_name_a  [NI];
  logic [VW-1:0] m_value_a [NI];
  logic          m_last_a  [NI];
  logic          busy_a    [NI];
  logic          qd_a      [NI];

  pair_t       exp_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          exp_done = 0;

  always #5 clk = ~clk;

  function automatic int k_of(int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 2);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned KK = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
    logic          st;
    logic [31:0]   nq;
    logic [VW-1:0] vq;
    assign st = start && (sel == g);

    knn_sort_sequencer #(.K(KK), .VAL_WIDTH(VW), .CNT_WIDTH(CW)) u_dut (
      .clk_i(clk), .reset_i(reset), .start_i(st), .cfg_count_i(cfg_count),
      .s_valid_i(s_valid), .s_value_i(s_value), .s_ready_o(s_ready_a[g]),
      .sort_clear_o(sclr_a[g]), .sort_valid_o(svld_a[g]), .sort_name_o(sname_a[g]),
      .sort_value_o(svalue_a[g]), .sort_done_o(sdone_a[g]), .sort_out_en_o(soe_a[g]),
      .sort_rd_en_o(srd_a[g]), .sort_name_q_i(nq), .sort_value_q_i(vq),
      .m_valid_o(m_valid_a[g]), .m_ready_i(m_ready), .m_name_o(m_name_a[g]),
      .m_value_o(m_value_a[g]), .m_last_o(m_last_a[g]), .busy_o(busy_a[g]),
      .query_done_o(qd_a[g]));

    // Sorter partner: K ascending slots, new entry goes after equal ones, registered read port
    initial begin : sorter
      logic [31:0]   en [KK];
      logic [VW-1:0] ev [KK];
      int            ptr;
      bit            armed;
      int            p;
      ptr = 0;
      armed = 0;
      for (int i = 0; i < KK; i++) begin en[i] = SENTINEL_NAME; ev[i] = '1; end
      forever begin
        @(posedge clk);
        if (sclr_a[g]) begin
          for (int i = 0; i < KK; i++) begin en[i] = SENTINEL_NAME; ev[i] = '1; end
          ptr = 0;
          armed = 0;
        end else begin
          if (svld_a[g]) begin
            p = KK;
            for (int i = KK - 1; i >= 0; i--) if (svalue_a[g] < ev[i]) p = i;
            if (p < KK) begin
              for (int i = KK - 1; i > p; i--) begin en[i] = en[i-1]; ev[i] = ev[i-1]; end
              en[p] = sname_a[g];
              ev[p] = svalue_a[g];
            end
          end
          if (sdone_a[g] && soe_a[g] && srd_a[g]) begin
            if (armed) begin
              if (ptr < KK - 1) ptr++;
              armed = 0;
            end else armed = 1;
          end
        end
        nq <= en[ptr];
        vq <= ev[ptr];
      end
    end
  end

  task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", what, act, exp);
    end
  endtask

  task automatic note_fail(input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: event count 0, required 1", what);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: stable ascending order of (index, value), first K, padded with sentinels
  task automatic push_exp(input int k, input int unsigned vals[$]);
    bit    used[];
    int    best;
    pair_t e;
    used = new[vals.size()];
    for (int j = 0; j < k; j++) begin
      best = -1;
      for (int i = 0; i < vals.size(); i++)
        if (!used[i] && (best < 0 || vals[i] < vals[best])) best = i;
      if (best >= 0) begin
        used[best] = 1'b1;
        e.name = 32'(best);
        e.value = VW'(vals[best]);
      end else begin
        e.name = SENTINEL_NAME;
        e.value = '1;
      end
      e.last = (j == k - 1);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake, checks stability while stalled
  initial begin : monitor
    logic [31:0]   hold_n;
    logic [VW-1:0] hold_v;
    logic          hold_l;
    bit            stalled;
    pair_t         e;
    stalled = 0;
    hold_n = '0; hold_v = '0; hold_l = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) stalled = 0;
      else begin
        if (qd_a[sel]) done_cnt++;
        if (stalled && !m_valid_a[sel]) chk("valid_dropped_in_stall", 64'(m_valid_a[sel]), 64'd1);
        if (m_valid_a[sel]) begin
          if (stalled) begin
            chk("stall_name", 64'(m_name_a[sel]), 64'(hold_n));
            chk("stall_value", 64'(m_value_a[sel]), 64'(hold_v));
            chk("stall_last", 64'(m_last_a[sel]), 64'(hold_l));
          end
          if (m_ready) begin
            stalled = 0;
            hs_cnt++;
            if (exp_q.size() == 0) note_fail("unexpected_pair");
            else begin
              e = exp_q.pop_front();
              chk("m_name", 64'(m_name_a[sel]), 64'(e.name));
              chk("m_value", 64'(m_value_a[sel]), 64'(e.value));
              chk("m_last", 64'(m_last_a[sel]), 64'(e.last));
            end
          end else begin
            stalled = 1;
            hold_n = m_name_a[sel];
            hold_v = m_value_a[sel];
            hold_l = m_last_a[sel];
          end
        end
      end
    end
  end

  initial begin : ready_drv
    int cyc;
    cyc = 0;
    forever begin
      tick();
      cyc++;
      if (rmode == 0) m_ready = 1'b1;
      else if (rmode == 1) m_ready = (cyc % 3 == 0);
      else if (rmode == 3) m_ready = 1'(($urandom_range(0, 1)));
    end
  end

  task automatic feed(input int unsigned vals[$], input bit gaps, input bit extra);
    int  t;
    bit  rdy;
    tick();
    start = 1'b1;
    cfg_count = CW'(vals.size());
    tick();
    start = 1'b0;
    cfg_count = CW'($urandom);
    if (extra) begin start = 1'b1; tick(); start = 1'b0; end
    foreach (vals[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin s_valid = 1'b0; s_value = VW'($urandom); tick(); end
      s_valid = 1'b1;
      s_value = VW'(vals[i]);
      t = 0;
      do begin rdy = s_ready_a[sel]; tick(); t++; end while (!rdy && t < 100);
      if (!rdy) note_fail("s_ready_timeout");
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((busy_a[sel] || exp_q.size() != 0) && t < 4000) begin tick(); t++; end
    if (t >= 4000) note_fail("query_timeout");
    repeat (2) tick();
    exp_done++;
    chk("query_done_count", 64'(done_cnt), 64'(exp_done));
    chk("pairs_left", 64'(exp_q.size()), 64'd0);
    chk("idle_sort_clear", 64'(sclr_a[sel]), 64'd1);
    chk("idle_busy", 64'(busy_a[sel]), 64'd0);
    exp_q.delete();
  endtask

  task automatic run_query(input int inst, input int unsigned vals[$], input bit gaps, input bit extra);
    sel = inst;
    push_exp(k_of(inst), vals);
    feed(vals, gaps, extra);
    wait_done();
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_ready", 64'(s_ready_a[sel]), 64'd0);
    chk("rst_sort_clear", 64'(sclr_a[sel]), 64'd1);
    chk("rst_sort_valid", 64'(svld_a[sel]), 64'd0);
    chk("rst_sort_name", 64'(sname_a[sel]), 64'd0);
    chk("rst_sort_value", 64'(svalue_a[sel]), 64'd0);
    chk("rst_sort_done", 64'(sdone_a[sel]), 64'd0);
    chk("rst_sort_out_en", 64'(soe_a[sel]), 64'd0);
    chk("rst_sort_rd_en", 64'(srd_a[sel]), 64'd0);
    chk("rst_m_valid", 64'(m_valid_a[sel]), 64'd0);
    chk("rst_m_name", 64'(m_name_a[sel]), 64'd0);
    chk("rst_m_value", 64'(m_value_a[sel]), 64'd0);
    chk("rst_m_last", 64'(m_last_a[sel]), 64'd0);
    chk("rst_busy", 64'(busy_a[sel]), 64'd0);
    chk("rst_query_done", 64'(qd_a[sel]), 64'd0);
  endtask

  initial begin : main
    int unsigned v[$];
    int          t;
    int          h0;
    int          n;

    s_valid = 1'b1;
    s_value = 32'd123;
    @(negedge clk);
    check_reset_outputs();
    tick();
    s_valid = 1'b0;
    reset = 1'b0;
    tick();

    v = {50, 10, 40, 20, 30, 60};
    rmode = 0; run_query(0, v, 1'b0, 1'b0);
    rmode = 1; run_query(0, v, 1'b0, 1'b0);
    rmode = 0;
    v = {7, 3};          run_query(0, v, 1'b0, 1'b0);
    v.delete();          run_query(0, v, 1'b0, 1'b0);
    v = {50, 10, 40, 20, 30, 60};
    run_query(0, v, 1'b1, 1'b1);
    v = {9, 9, 2};       run_query(1, v, 1'b0, 1'b0);
    v = {5, 5};          run_query(2, v, 1'b0, 1'b0);

    // Abort while the second pair is presented
    sel = 0;
    v = {50, 10, 40, 20, 30, 60};
    push_exp(4, v);
    h0 = hs_cnt;
    feed(v, 1'b0, 1'b0);
    t = 0;
    while (hs_cnt == h0 && t < 200) begin tick(); t++; end
    if (hs_cnt == h0) note_fail("first_pair_timeout");
    rmode = 2;
    m_ready = 1'b0;
    t = 0;
    while (!m_valid_a[0] && t < 200) begin tick(); t++; end
    if (!m_valid_a[0]) note_fail("second_pair_timeout");
    tick();
    reset = 1'b1;
    s_valid = 1'b1;
    s_value = 32'd77;
    @(negedge clk);
    check_reset_outputs();
    tick();
    reset = 1'b0;
    s_valid = 1'b0;
    exp_q.delete();
    rmode = 0;
    repeat (4) tick();
    chk("no_done_after_abort", 64'(done_cnt), 64'(exp_done));
    v = {50, 10, 40, 20, 30, 60};
    run_query(0, v, 1'b0, 1'b0);

    // Randomized queries across all three K configurations
    for (int q = 0; q < 30; q++) begin
      v.delete();
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) v.push_back($urandom_range(0, 60));
      rmode = (q % 3 == 2) ? 3 : (q % 3);
      run_query($urandom_range(0, 2), v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
